uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Transmit half of the APB UART core. It sits directly downstream of the APB register decoder: writes to the transmit holding register land in a 16-entry TX FIFO. A line-control-driven serializer drains the FIFO onto `TXD`, timed by the 16x oversampling enable from the baud generator (the same tick exported as `baud_o`). It also produces the THRE/TEMT status consumed by the line-status register and interrupt logic.

## Interface
- `DEPTH`, 16: TX FIFO entries; must be a power of two.
- `AW`, 4: log2(`DEPTH`).
- `clk`  in  1  system clock; all state updates on its rising edge.
- `Preset`  in  1  asynchronous, active-high reset.
- `baud_tick`  in  1  16x-baud enable, one `clk` wide; equals `baud_o`.
- `wr_en`  in  1  THR write strobe from the APB decoder (`Psel & Penable & Pwrite`, THR address).
- `wr_data`  in  8  byte to transmit (`Pwdata[7:0]`).
- `fifo_en`  in  1  FCR[0]. 1 selects `DEPTH`-entry FIFO; 0 selects single-entry holding register.
- `tx_fifo_rst`  in  1  FCR[2] pulse; synchronous FIFO clear.
- `lcr`  in  8  line control: [1:0] WLS (word length 5+WLS), [2] STB, [3] PEN, [4] EPS, [5] SP, [6] BC.
- `TXD`  out  1  serial output, idle high.
- `tx_count`  out  AW+1  FIFO occupancy.
- `tx_full`  out  1  FIFO full (count == `DEPTH`, or 1 when `fifo_en`=0).
- `thre`  out  1  FIFO empty.
- `temt`  out  1  FIFO empty and serializer idle.
- `tx_overflow`  out  1  one-cycle pulse when a write is dropped.

## Operation
- **FIFO**
  - Circular buffer with AW-bit read/write pointers and an AW+1-bit count.
  - A write while `tx_full` and no pop in the same cycle is dropped and pulses `tx_overflow`.
  - A simultaneous write and pop when full accepts the write; count is unchanged.
  - `tx_fifo_rst` zeroes the pointers and count. It takes priority over a same-cycle write, which is then dropped without an overflow pulse. It does not abort a frame in flight.
- **Serializer FSM** states: IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** if count > 0, pop the head byte into the shift register and latch `lcr[5:0]` for the frame. Later `lcr` changes affect only the next frame. Clear the tick counter and go to START.
  - **START:** `TXD`=0 for 16 ticks, then DATA.
  - **DATA:** shift LSB first, 5+WLS bits at 16 ticks each. Then PARITY if PEN, else STOP.
  - **PARITY:** one bit.
    - SP=0: XOR of the data bits, inverted when EPS=0 (odd parity).
    - SP=1: the bit is ~EPS.
  - **STOP:** `TXD`=1.
    - STB=0: 16 ticks.
    - STB=1 with WLS=00: 24 ticks.
    - STB=1 otherwise: 32 ticks.
  - After STOP, return to IDLE. A pending byte is popped in that IDLE cycle, so frames go back to back with no idle gap beyond one `clk`.
- **Bit timing:** a 4-bit tick counter advances only on `baud_tick`. A bit ends on the tick that takes the counter 15→0; stop lengths above 16 extend via a 5-bit stop counter.
- **Break:** `TXD` = `txd_q & ~lcr[6]`, registered. The FSM keeps running under break, so data is consumed.
- `temt` = `thre` & (state == IDLE).

## Timing
- **Reset values:** `TXD`=1, `tx_count`=0, `tx_full`=0, `thre`=1, `temt`=1, `tx_overflow`=0, FSM in IDLE, pointers 0.
- **Write to start-bit latency (idle serializer):**
  - `wr_en` sampled at edge N.
  - `thre` falls after edge N.
  - Pop and START entry at edge N+1.
  - `TXD` falls after edge N+2.
- **Frame length in ticks:** 16 × (1 + data bits + PEN + 1) for STB=0, e.g. 8N1 = 160 and 7E1 = 160. 8N2 = 176; 5N1.5 = 120.
- `tx_overflow` is high for exactly the cycle following the dropped write.
- Reset asserted mid-frame forces `TXD`=1 immediately (asynchronous) and discards the FIFO contents.
- Status outputs are registered and update one `clk` after the causing edge.

## Test plan
- Reset: assert `Preset` for 3 cycles mid-frame -> `TXD`=1, `thre`=1, `temt`=1, `tx_count`=0 during and after reset.
- `lcr`=8'h03, write 8'hA5, `baud_tick` every 4 clk -> `TXD` carries 0,1,0,1,0,0,1,0,1,1, each bit 64 clk; `temt` rises after 640 clk plus latency.
- Parity sweep, data 8'h07, WLS=11: PEN=1 EPS=1 -> parity 1; EPS=0 -> 0; SP=1 EPS=1 -> 0; SP=1 EPS=0 -> 1. `lcr`=8'h04 with WLS=00 -> stop lasts 24 ticks.
- Write 17 bytes back to back with `fifo_en`=1 and the serializer stalled (no ticks) -> first byte popped, 16 queued, `tx_full`=1; the 18th write pulses `tx_overflow`, `tx_count` stays 16.
- `fifo_en`=0: two consecutive writes while idle -> both accepted (first popped). A third write before the frame ends is accepted into the single slot; a fourth pulses `tx_overflow`.
- Set BC mid-frame -> `TXD`=0 from the next clk; clear BC after 2 frames -> `TXD`=1, and the FIFO count has dropped by 2.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// TX half of the APB UART: DEPTH-entry THR FIFO draining into a 16x-oversampled start/data/parity/stop serializer.
// Latency: write at edge N -> pop at N+1 -> TXD start bit after N+2; status outputs one clk after the causing edge.
// Backpressure: none upstream; a write into a full FIFO is dropped and flagged on tx_overflow.
module uart_tx_serializer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          Preset,
    input  logic          baud_tick,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          fifo_en,
    input  logic          tx_fifo_rst,
    input  logic [7:0]    lcr,
    output logic          TXD,
    output logic [AW:0]   tx_count,
    output logic          tx_full,
    output logic          thre,
    output logic          temt,
    output logic          tx_overflow
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count_nxt;
    logic          full_c, pop, push, drop;
    logic [7:0]    head, head_mask;
    logic          head_par;
    logic [7:0]    shreg;
    logic [3:0]    frm_cfg;
    logic          par_bit;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_cnt;
    logic [4:0]    stop_cnt, stop_last;
    logic          txd_q;
    logic          unused_lcr;

    assign unused_lcr = lcr[7];

    always_comb begin
        full_c    = fifo_en ? (tx_count == DEPTH_C) : (tx_count != '0);
        pop       = (state == IDLE) && (tx_count != '0);
        push      = wr_en && !tx_fifo_rst && (!full_c || pop);
        drop      = wr_en && !tx_fifo_rst && full_c && !pop;
        count_nxt = tx_count;
        if (tx_fifo_rst)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = tx_count + (AW+1)'(1);
        else if (pop && !push)
            count_nxt = tx_count - (AW+1)'(1);
        // Parity is fixed at pop time from the frame's own word length and mode bits.
        head      = mem[rd_ptr];
        head_mask = head & (8'hFF >> (2'd3 - lcr[1:0]));
        head_par  = lcr[5] ? ~lcr[4] : ((^head_mask) ^ ~lcr[4]);
        stop_last = !frm_cfg[2] ? 5'd15 : (frm_cfg[1:0] == 2'b00) ? 5'd23 : 5'd31;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge Preset) begin
        if (Preset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tx_count    <= '0;
            tx_full     <= 1'b0;
            thre        <= 1'b1;
            tx_overflow <= 1'b0;
        end else begin
            tx_count    <= count_nxt;
            tx_full     <= fifo_en ? (count_nxt == DEPTH_C) : (count_nxt != '0);
            thre        <= (count_nxt == '0);
            tx_overflow <= drop;
            if (tx_fifo_rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge Preset) begin
        if (Preset) begin
            state    <= IDLE;
            txd_q    <= 1'b1;
            TXD      <= 1'b1;
            shreg    <= '0;
            frm_cfg  <= '0;
            par_bit  <= 1'b0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
        end else begin
            // Break gates the line only; the FSM keeps consuming bytes underneath.
            TXD <= txd_q & ~lcr[6];
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg    <= head;
                        frm_cfg  <= lcr[3:0];
                        par_bit  <= head_par;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        stop_cnt <= '0;
                        txd_q    <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            txd_q <= shreg[0];
                            shreg <= shreg >> 1;
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            if (bit_cnt == {1'b1, frm_cfg[1:0]}) begin
                                stop_cnt <= '0;
                                txd_q    <= frm_cfg[3] ? par_bit : 1'b1;
                                state    <= frm_cfg[3] ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                txd_q   <= shreg[0];
                                shreg   <= shreg >> 1;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            stop_cnt <= '0;
                            txd_q    <= 1'b1;
                            state    <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt == stop_last)
                            state <= IDLE;
                        else
                            stop_cnt <= stop_cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign temt = thre && (state == IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: reset, framing, parity/stop variants, FIFO full/overflow, single-slot mode, break.
module tb_uart_tx_serializer;

    logic       clk, Preset, baud_tick, wr_en, fifo_en, tx_fifo_rst;
    logic [7:0] wr_data, lcr;
    logic       TXD, tx_full, thre, temt, tx_overflow;
    logic [4:0] tx_count;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_div = 0;
    int cyc      = 0;
    int t_fall   = 0;
    int t_temt   = 0;

    uart_tx_serializer #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .Preset(Preset), .baud_tick(baud_tick), .wr_en(wr_en),
        .wr_data(wr_data), .fifo_en(fifo_en), .tx_fifo_rst(tx_fifo_rst), .lcr(lcr),
        .TXD(TXD), .tx_count(tx_count), .tx_full(tx_full), .thre(thre),
        .temt(temt), .tx_overflow(tx_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // baud_tick: one clk high every tick_div clks; tick_div = 0 stalls the serializer.
    initial begin
        int ph;
        ph = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_div == 0) begin
                baud_tick = 1'b0;
                ph = 0;
            end else begin
                baud_tick = (ph == 0);
                ph = (ph + 1 >= tick_div) ? 0 : ph + 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        Preset = 1'b1;
        repeat (2) @(negedge clk);
        Preset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_txd_low(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (TXD === 1'b0) begin
                ok = 1'b1;
                t_fall = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_temt(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (temt === 1'b1) begin
                ok = 1'b1;
                t_temt = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic capture_frame(input int nbits, input int per, output logic [15:0] bits, output bit ok);
        bits = '1;
        wait_txd_low(400, ok);
        if (!ok) return;
        repeat (per / 2) @(negedge clk);
        bits[0] = TXD;
        for (int i = 1; i < nbits; i++) begin
            repeat (per) @(negedge clk);
            bits[i] = TXD;
        end
    endtask

    task automatic test_reset();
        bit ok;
        bit stay;
        Preset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if ({TXD, thre, temt} !== 3'b111) begin n_fail++; $display("FAIL reset_lines: TXD/thre/temt got %b want 111", {TXD, thre, temt}); end
        n_checks++; if (tx_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", tx_count); end
        n_checks++; if ({tx_full, tx_overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_full_ovf: got %b want 00", {tx_full, tx_overflow}); end
        Preset = 1'b0;
        lcr = 8'h03; tick_div = 1;
        wr_data = 8'h00; wr_en = 1'b1;
        repeat (3) @(negedge clk);
        wr_en = 1'b0;
        wait_txd_low(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL reset_frame_start: TXD never fell"); end
        n_checks++; if (tx_count !== 5'd2) begin n_fail++; $display("FAIL reset_prefill: count got %0d want 2", tx_count); end
        repeat (20) @(negedge clk);
        Preset = 1'b1;
        #1;
        n_checks++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL reset_async_txd: got %b want 1", TXD); end
        stay = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if ({TXD, thre, temt, tx_count} !== {3'b111, 5'd0}) stay = 1'b0;
        end
        Preset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if ({TXD, thre, temt, tx_count} !== {3'b111, 5'd0}) stay = 1'b0;
        end
        n_checks++; if (!stay) begin n_fail++; $display("FAIL reset_hold: outputs left idle during/after reset, now TXD=%b count=%0d", TXD, tx_count); end
    endtask

    task automatic test_frame_a5();
        bit ok;
        logic [15:0] bits;
        do_reset();
        lcr = 8'h03; tick_div = 4; fifo_en = 1'b1;
        wr_data = 8'hA5; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if (thre !== 1'b0) begin n_fail++; $display("FAIL a5_thre_fall: got %b want 0", thre); end
        capture_frame(10, 64, bits, ok);
        n_checks++; if (!ok || bits[9:0] !== 10'b1_10100101_0) begin n_fail++; $display("FAIL a5_bits: got %b want 1101001010", bits[9:0]); end
        n_checks++; if (temt !== 1'b0) begin n_fail++; $display("FAIL a5_temt_busy: got %b want 0", temt); end
        wait_temt(200, ok);
        // 160 ticks of 4 clk, first tick 1..4 clk after the pop edge, TXD one clk behind the pop.
        n_checks++; if (!ok || (t_temt - t_fall) < 636 || (t_temt - t_fall) > 639) begin n_fail++; $display("FAIL a5_temt_time: got %0d clk want 636..639", t_temt - t_fall); end
    endtask

    task automatic test_parity_stop();
        bit ok;
        logic [15:0] bits;
        logic [7:0] lcrs [4] = '{8'h1B, 8'h0B, 8'h3B, 8'h2B};
        logic       pars [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        tick_div = 1;
        for (int k = 0; k < 4; k++) begin
            lcr = lcrs[k];
            wr_data = 8'h07; wr_en = 1'b1;
            @(negedge clk);
            wr_en = 1'b0;
            capture_frame(11, 16, bits, ok);
            n_checks++; if (!ok || bits[10:0] !== {1'b1, pars[k], 8'h07, 1'b0}) begin n_fail++; $display("FAIL parity_%0d: got %b want %b", k, bits[10:0], {1'b1, pars[k], 8'h07, 1'b0}); end
            wait_temt(100, ok);
        end
        // Continuous ticks: fall-to-temt is the frame tick count minus one clk of TXD register delay.
        lcr = 8'h04;
        wr_data = 8'h07; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        wait_txd_low(10, ok);
        wait_temt(300, ok);
        n_checks++; if (!ok || (t_temt - t_fall) != 119) begin n_fail++; $display("FAIL stop_5n15: got %0d clk want 119", t_temt - t_fall); end
        lcr = 8'h07;
        wr_data = 8'h5A; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        wait_txd_low(10, ok);
        wait_temt(300, ok);
        n_checks++; if (!ok || (t_temt - t_fall) != 175) begin n_fail++; $display("FAIL stop_8n2: got %0d clk want 175", t_temt - t_fall); end
    endtask

    task automatic test_overflow();
        do_reset();
        tick_div = 0; fifo_en = 1'b1; lcr = 8'h03;
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'(i + 1); wr_en = 1'b1;
            @(negedge clk);
        end
        n_checks++; if ({tx_count, tx_full, tx_overflow} !== {5'd16, 2'b10}) begin n_fail++; $display("FAIL ovf_fill: count/full/ovf got %0d/%b/%b want 16/1/0", tx_count, tx_full, tx_overflow); end
        wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if ({tx_count, tx_overflow} !== {5'd16, 1'b1}) begin n_fail++; $display("FAIL ovf_drop: count/ovf got %0d/%b want 16/1", tx_count, tx_overflow); end
        @(negedge clk);
        n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse_width: got %b want 0", tx_overflow); end
        wr_en = 1'b1; tx_fifo_rst = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; tx_fifo_rst = 1'b0;
        n_checks++; if ({tx_count, thre, tx_full, tx_overflow} !== {5'd0, 3'b100}) begin n_fail++; $display("FAIL fifo_clear: count/thre/full/ovf got %0d/%b/%b/%b want 0/1/0/0", tx_count, thre, tx_full, tx_overflow); end
        n_checks++; if ({TXD, temt} !== 2'b00) begin n_fail++; $display("FAIL clear_keeps_frame: TXD/temt got %b want 00", {TXD, temt}); end
    endtask

    task automatic test_single_slot();
        bit ok;
        do_reset();
        fifo_en = 1'b0; tick_div = 1; lcr = 8'h03;
        wr_data = 8'hA1; wr_en = 1'b1;
        @(negedge clk);
        wr_data = 8'hA2;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if ({tx_count, tx_full, tx_overflow} !== {5'd1, 2'b10}) begin n_fail++; $display("FAIL slot_two_writes: count/full/ovf got %0d/%b/%b want 1/1/0", tx_count, tx_full, tx_overflow); end
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_count === 5'd0) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL slot_second_pop: count stuck at %0d want 0", tx_count); end
        wr_data = 8'hA3; wr_en = 1'b1;
        @(negedge clk);
        n_checks++; if ({tx_count, tx_overflow} !== {5'd1, 1'b0}) begin n_fail++; $display("FAIL slot_third: count/ovf got %0d/%b want 1/0", tx_count, tx_overflow); end
        wr_data = 8'hA4;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if ({tx_count, tx_overflow} !== {5'd1, 1'b1}) begin n_fail++; $display("FAIL slot_fourth: count/ovf got %0d/%b want 1/1", tx_count, tx_overflow); end
    endtask

    task automatic test_break();
        bit ok;
        bit low;
        do_reset();
        fifo_en = 1'b1; tick_div = 1; lcr = 8'h03;
        wr_data = 8'hFF; wr_en = 1'b1;
        repeat (4) @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if (tx_count !== 5'd3) begin n_fail++; $display("FAIL brk_prefill: count got %0d want 3", tx_count); end
        wait_txd_low(10, ok);
        repeat (24) @(negedge clk);
        n_checks++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL brk_pre_data: got %b want 1", TXD); end
        lcr = 8'h43;
        @(negedge clk);
        n_checks++; if (TXD !== 1'b0) begin n_fail++; $display("FAIL brk_assert: got %b want 0", TXD); end
        low = 1'b1;
        repeat (320) begin
            @(negedge clk);
            if (TXD !== 1'b0) low = 1'b0;
        end
        n_checks++; if (!low) begin n_fail++; $display("FAIL brk_hold: TXD went high under break, now %b want 0", TXD); end
        n_checks++; if (tx_count !== 5'd1) begin n_fail++; $display("FAIL brk_consumed: count got %0d want 1", tx_count); end
        lcr = 8'h03;
        @(negedge clk);
        n_checks++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL brk_release: got %b want 1", TXD); end
    endtask

    initial begin
        Preset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; fifo_en = 1'b1;
        tx_fifo_rst = 1'b0; lcr = 8'h03;
        @(negedge clk);
        test_reset();
        test_frame_a5();
        test_parity_stop();
        test_overflow();
        test_single_slot();
        test_break();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
